// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    // Master indices; also the bit positions in the one-hot grant vector.
    localparam logic M_IF  = 1'b0;
    localparam logic M_MEM = 1'b1;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus watchdog: counts stalled strobe cycles and fires on the last allowed one.
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en,
    input  logic clr,
    output logic fire
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_d, cnt_q;

    // Next count: clear wins over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fire only in a cycle that is itself still stalled, so a same-cycle ack wins.
    assign fire = en && !clr && (cnt_q == LastCnt);

endmodule

// File: rtl/wb_arbiter_wdt.sv
// Two-master Wishbone arbiter (M0 instruction fetch, M1 data) with starvation
// guard and bus watchdog in front of a shared slave port.
module wb_arbiter_wdt
    import wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SEL_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned ROUND_ROBIN = 0,
    parameter int unsigned MAX_CONSEC  = 8,
    parameter int unsigned TIMEOUT     = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // Master 0 (instruction fetch)
    input  logic [ADDR_WIDTH-1:0] wbm0_adr_i,
    input  logic [DATA_WIDTH-1:0] wbm0_dat_i,
    input  logic [SEL_WIDTH-1:0]  wbm0_sel_i,
    input  logic                  wbm0_we_i,
    input  logic                  wbm0_stb_i,
    input  logic                  wbm0_cyc_i,
    output logic [DATA_WIDTH-1:0] wbm0_dat_o,
    output logic                  wbm0_ack_o,
    output logic                  wbm0_err_o,
    // Master 1 (data access)
    input  logic [ADDR_WIDTH-1:0] wbm1_adr_i,
    input  logic [DATA_WIDTH-1:0] wbm1_dat_i,
    input  logic [SEL_WIDTH-1:0]  wbm1_sel_i,
    input  logic                  wbm1_we_i,
    input  logic                  wbm1_stb_i,
    input  logic                  wbm1_cyc_i,
    output logic [DATA_WIDTH-1:0] wbm1_dat_o,
    output logic                  wbm1_ack_o,
    output logic                  wbm1_err_o,
    // Shared slave port
    output logic [ADDR_WIDTH-1:0] wbs_adr_o,
    output logic [DATA_WIDTH-1:0] wbs_dat_o,
    output logic [SEL_WIDTH-1:0]  wbs_sel_o,
    output logic                  wbs_we_o,
    output logic                  wbs_stb_o,
    output logic                  wbs_cyc_o,
    input  logic [DATA_WIDTH-1:0] wbs_dat_i,
    input  logic                  wbs_ack_i,
    input  logic                  wbs_err_i,
    // Status
    output logic [1:0]            gnt_o,
    output logic                  abort_o
);

    localparam int unsigned CW = $clog2(MAX_CONSEC + 1);
    localparam logic [CW-1:0] MaxConsec = CW'(MAX_CONSEC);

    arb_state_e    state_d, state_q;
    logic [1:0]    gnt_d, gnt_q;
    logic          last_d, last_q;
    logic [CW-1:0] consec_d, consec_q;

    logic win, have_last, starved;
    logic gsel, g_cyc, g_stb, g_we;
    logic [ADDR_WIDTH-1:0] g_adr;
    logic [DATA_WIDTH-1:0] g_dat;
    logic [SEL_WIDTH-1:0]  g_sel;
    logic busy, live, ack_g, err_g;
    logic wd_en, wd_clr, wd_fire;

    // consec_q == 0 only after reset, i.e. nobody has been granted yet.
    assign have_last = (consec_q != '0);
    assign starved   = have_last && (consec_q == MaxConsec);

    // Arbitration winner among currently requesting masters.
    always_comb begin
        win = M_MEM;
        if (wbm0_cyc_i && !wbm1_cyc_i) begin
            win = M_IF;
        end else if (wbm1_cyc_i && !wbm0_cyc_i) begin
            win = M_MEM;
        end else if (starved) begin
            win = ~last_q;
        end else if ((ROUND_ROBIN != 0) && have_last) begin
            win = ~last_q;
        end
    end

    // Granted-master request mux.
    assign gsel  = gnt_q[M_MEM];
    assign g_cyc = gsel ? wbm1_cyc_i : wbm0_cyc_i;
    assign g_stb = gsel ? wbm1_stb_i : wbm0_stb_i;
    assign g_we  = gsel ? wbm1_we_i  : wbm0_we_i;
    assign g_adr = gsel ? wbm1_adr_i : wbm0_adr_i;
    assign g_dat = gsel ? wbm1_dat_i : wbm0_dat_i;
    assign g_sel = gsel ? wbm1_sel_i : wbm0_sel_i;

    // FSM next state, grant and consecutive-grant bookkeeping.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        consec_d = consec_q;
        case (state_q)
            IDLE: begin
                if (wbm0_cyc_i || wbm1_cyc_i) begin
                    state_d = BUSY;
                    gnt_d   = (win == M_MEM) ? 2'b10 : 2'b01;
                    last_d  = win;
                    if (have_last && (win == last_q)) begin
                        consec_d = starved ? consec_q : consec_q + 1'b1;
                    end else begin
                        consec_d = CW'(1);
                    end
                end
            end
            BUSY: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                end else if (wd_fire) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // State, grant and counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            gnt_q    <= 2'b00;
            last_q   <= M_IF;
            consec_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            consec_q <= consec_d;
        end
    end

    assign busy  = (state_q == BUSY);
    assign live  = busy && g_cyc;
    assign ack_g = live && wbs_ack_i;
    assign err_g = live && wbs_err_i;

    // Stalled strobe cycles only; any response or idle strobe restarts the count.
    assign wd_en  = live && g_stb && !wbs_ack_i && !wbs_err_i;
    assign wd_clr = !wd_en;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en     (wd_en),
        .clr    (wd_clr),
        .fire   (wd_fire)
    );

    // Slave-side and master-side output muxing.
    always_comb begin
        wbs_cyc_o  = live;
        wbs_stb_o  = live && g_stb;
        wbs_adr_o  = busy ? g_adr : '0;
        wbs_dat_o  = busy ? g_dat : '0;
        wbs_sel_o  = busy ? g_sel : '0;
        wbs_we_o   = busy && g_we;
        abort_o    = (state_q == ABORT);
        wbm0_ack_o = ack_g && (gsel == M_IF);
        wbm1_ack_o = ack_g && (gsel == M_MEM);
        wbm0_err_o = (err_g || abort_o) && (gsel == M_IF);
        wbm1_err_o = (err_g || abort_o) && (gsel == M_MEM);
        wbm0_dat_o = busy ? wbs_dat_i : '0;
        wbm1_dat_o = busy ? wbs_dat_i : '0;
        gnt_o      = gnt_q;
    end

endmodule

// File: tb/tb_wb_arbiter_wdt.sv
// Scoreboard bench for wb_arbiter_wdt: masters push expected responses,
// a negedge monitor pops and compares whenever an ack/err appears.
`timescale 1ns/1ps
module tb_wb_arbiter_wdt;

    localparam int TO = 16;
    localparam int MC = 8;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        int          kind;  // 0 ack, 1 slave err, 2 watchdog abort
        int          lat;   // cycles from first slave strobe to response
    } txn_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [3:0]  m_sel [2];
    logic        m_we  [2];
    logic        m_stb [2];
    logic        m_cyc [2];
    logic [31:0] m_rdat [2];
    logic        m_ack [2];
    logic        m_err [2];

    logic [31:0] wbs_adr_o, wbs_dat_o, wbs_dat_i;
    logic [3:0]  wbs_sel_o;
    logic        wbs_we_o, wbs_stb_o, wbs_cyc_o, wbs_ack_i, wbs_err_i;
    logic [1:0]  gnt_o;
    logic        abort_o;

    wb_arbiter_wdt #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .SEL_WIDTH   (4),
        .ROUND_ROBIN (0),
        .MAX_CONSEC  (MC),
        .TIMEOUT     (TO)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wbm0_adr_i (m_adr[0]),
        .wbm0_dat_i (m_dat[0]),
        .wbm0_sel_i (m_sel[0]),
        .wbm0_we_i  (m_we[0]),
        .wbm0_stb_i (m_stb[0]),
        .wbm0_cyc_i (m_cyc[0]),
        .wbm0_dat_o (m_rdat[0]),
        .wbm0_ack_o (m_ack[0]),
        .wbm0_err_o (m_err[0]),
        .wbm1_adr_i (m_adr[1]),
        .wbm1_dat_i (m_dat[1]),
        .wbm1_sel_i (m_sel[1]),
        .wbm1_we_i  (m_we[1]),
        .wbm1_stb_i (m_stb[1]),
        .wbm1_cyc_i (m_cyc[1]),
        .wbm1_dat_o (m_rdat[1]),
        .wbm1_ack_o (m_ack[1]),
        .wbm1_err_o (m_err[1]),
        .wbs_adr_o  (wbs_adr_o),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_sel_o  (wbs_sel_o),
        .wbs_we_o   (wbs_we_o),
        .wbs_stb_o  (wbs_stb_o),
        .wbs_cyc_o  (wbs_cyc_o),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_i  (wbs_ack_i),
        .wbs_err_i  (wbs_err_i),
        .gnt_o      (gnt_o),
        .abort_o    (abort_o)
    );

    int   checks = 0;
    int   failures = 0;
    int   cyc_n = 0;
    int   stb_start = 0;
    int   slv_cnt = 0;
    logic prev_stb = 1'b0;
    logic [1:0] prev_gnt = 2'b00;
    logic chk_gnt = 1'b0;
    txn_t q0[$];
    txn_t q1[$];
    int   exp_gnt_q[$];

    // Slave behaviour: latency = (adr[4:0]+2) mod 32 cycles, adr[5] selects an error reply.
    function automatic int slv_lat(input logic [31:0] a);
        logic [4:0] l;
        l = a[4:0] + 5'd2;
        return int'(l);
    endfunction

    function automatic logic [31:0] slv_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Issue one transaction on master m and push its predicted outcome.
    task automatic m_txn(input int m, input logic [31:0] adr, input logic we,
                         input logic [31:0] dat, input logic [3:0] sel);
        txn_t t;
        int   n;
        t.adr = adr; t.dat = dat; t.sel = sel; t.we = we;
        if (slv_lat(adr) >= TO) begin
            t.kind = 2; t.lat = TO;
        end else begin
            t.kind = adr[5] ? 1 : 0; t.lat = slv_lat(adr);
        end
        if (m == 0) q0.push_back(t); else q1.push_back(t);
        @(posedge clk); #1;
        m_adr[m] = adr; m_dat[m] = dat; m_sel[m] = sel; m_we[m] = we;
        m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_ack[m] || m_err[m]) && n < 200);
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL m%0d_response_timeout: got none expected ack/err within 200 cycles", m);
        end
        @(posedge clk); #1;
        m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
    endtask

    // Slave model.
    initial begin
        wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_dat_i = '0;
        forever begin
            @(posedge clk); #2;
            wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_dat_i = '0;
            if (wbs_stb_o) begin
                if (slv_cnt == slv_lat(wbs_adr_o)) begin
                    if (wbs_adr_o[5]) wbs_err_i = 1'b1;
                    else begin
                        wbs_ack_i = 1'b1;
                        wbs_dat_i = slv_data(wbs_adr_o);
                    end
                    slv_cnt = 0;
                end else begin
                    slv_cnt++;
                end
            end else begin
                slv_cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every master response and on every new grant.
    initial begin
        txn_t t;
        int   gk;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (wbs_stb_o && !prev_stb) stb_start = cyc_n;
            if (chk_gnt && gnt_o != 2'b00 && prev_gnt == 2'b00) begin
                if (exp_gnt_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL grant_unexpected: got %b expected none", gnt_o);
                end else begin
                    gk = exp_gnt_q.pop_front();
                    check("grant_order", gnt_o, (gk == 1) ? 2'b10 : 2'b01);
                end
            end
            if (abort_o && !(m_err[0] || m_err[1])) begin
                checks++; failures++;
                $display("FAIL abort_without_err: got abort_o=1 expected an err with it");
            end
            for (int m = 0; m < 2; m++) begin
                if (m_ack[m] || m_err[m]) begin
                    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
                        checks++; failures++;
                        $display("FAIL m%0d_unexpected_response: got ack=%b err=%b expected none",
                                 m, m_ack[m], m_err[m]);
                    end else begin
                        t = (m == 0) ? q0.pop_front() : q1.pop_front();
                        gk = m_ack[m] ? 0 : (abort_o ? 2 : 1);
                        check("resp_kind", gk, t.kind);
                        check("resp_latency", cyc_n - stb_start, t.lat);
                        check("abort_flag", abort_o, (t.kind == 2));
                        if (m_ack[m]) check("read_data", m_rdat[m], slv_data(t.adr));
                        if (t.kind != 2)
                            check("slave_request", {wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o},
                                  {t.adr, t.dat, t.sel, t.we});
                    end
                end
            end
            prev_stb = wbs_stb_o;
            prev_gnt = gnt_o;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_adr[m] = 32'h0000_0010 << m; m_dat[m] = '0; m_sel[m] = 4'hF; m_we[m] = 1'b0;
            m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
        end
        // Reset held with both masters requesting.
        repeat (3) begin
            @(negedge clk);
            check("rst_gnt", gnt_o, 2'b00);
            check("rst_wbs_cyc", {wbs_cyc_o, wbs_stb_o}, 2'b00);
            check("rst_ack_err", {m_ack[0], m_ack[1], m_err[0], m_err[1], abort_o}, 5'b0);
        end
        @(posedge clk); #1;
        for (int m = 0; m < 2; m++) begin m_cyc[m] = 1'b0; m_stb[m] = 1'b0; end
        rst_n = 1'b1;

        // Single M0 read: slave sees it one cycle after cyc, acks 2 cycles later.
        fork
            m_txn(0, 32'h8000_0000, 1'b0, 32'h0, 4'hF);
            begin
                @(posedge clk);
                @(negedge clk); check("cyc_delay_idle", wbs_cyc_o, 1'b0);
                @(negedge clk); check("cyc_delay_busy", wbs_cyc_o, 1'b1);
                check("single_gnt_m0", gnt_o, 2'b01);
            end
        join

        // Watchdog boundaries: ack on last allowed cycle, then two timeouts.
        m_txn(0, 32'h0000_000D, 1'b0, 32'h0, 4'hF);
        m_txn(0, 32'h0000_101D, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        check("idle_after_abort", {wbs_cyc_o, gnt_o, abort_o}, 4'b0);
        m_txn(0, 32'h0000_000E, 1'b0, 32'h0, 4'h3);
        // Slave error forwarded without abort.
        m_txn(0, 32'h0000_0021, 1'b0, 32'h0, 4'hF);
        // M1 write.
        m_txn(1, 32'h4000_0104, 1'b1, 32'hDEAD_BEEF, 4'h5);

        // Simultaneous requests: M1 first, M0 after M1 drops cyc.
        chk_gnt = 1'b1;
        exp_gnt_q.push_back(1); exp_gnt_q.push_back(0);
        fork
            m_txn(0, 32'h1000_0040, 1'b0, 32'h0, 4'hF);
            m_txn(1, 32'h2000_0080, 1'b1, 32'h1234_5678, 4'hF);
        join

        // Starvation guard: M1 back-to-back, M0 waits for MAX_CONSEC M1 grants.
        for (int i = 0; i < MC; i++) exp_gnt_q.push_back(1);
        exp_gnt_q.push_back(0); exp_gnt_q.push_back(1);
        fork
            m_txn(0, 32'h3000_0000, 1'b0, 32'h0, 4'hF);
            for (int i = 0; i < MC + 1; i++) m_txn(1, 32'h5000_0000 + 32'(i * 64), 1'b0, 32'h0, 4'hF);
        join
        @(negedge clk);
        check("grant_queue_drained", exp_gnt_q.size(), 0);
        chk_gnt = 1'b0;

        // Reset mid-transfer: bus released on the next edge, nothing emitted.
        @(posedge clk); #1;
        m_adr[0] = 32'h0000_001D; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk); check("rst_sync_hold", wbs_cyc_o, 1'b1);
        @(posedge clk); #1;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", {wbs_cyc_o, gnt_o, m_ack[0], m_err[0], abort_o}, 6'b0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Randomised concurrent traffic from both masters.
        fork
            for (int i = 0; i < 20; i++) begin
                logic [31:0] a;
                a = $urandom;
                if ($urandom_range(0, 3) != 0) a[4:0] = 5'($urandom_range(0, 12));
                repeat ($urandom_range(0, 3)) @(posedge clk);
                m_txn(0, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
            end
            for (int j = 0; j < 20; j++) begin
                logic [31:0] b;
                b = $urandom;
                if ($urandom_range(0, 3) != 0) b[4:0] = 5'($urandom_range(0, 12));
                repeat ($urandom_range(0, 3)) @(posedge clk);
                m_txn(1, b, 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
            end
        join
        repeat (3) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("final_idle", {wbs_cyc_o, gnt_o}, 3'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
